// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the multi-cycle shifter.
//                Provides the shift-operation enum, the shifter state enum
//                and the default datapath width constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_width   = 32;
    localparam int c_shamt_w = 5;

    typedef enum logic [1:0] {
        SH_SRL = 2'd0,
        SH_SRA = 2'd1,
        SH_SLL = 2'd2
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational single-step shifter. Shifts 'work' by 's'
//                bits, right with 'fill' replicated into the vacated MSBs,
//                or (only when SHIFT_LEFT_EN is defined) left with zero fill
//                when 'dir' is 1.
//  Ports       : work      in  WIDTH    current working value
//                s         in  SHAMT_W  bits to shift this step
//                fill      in  1        bit shifted in on right shifts
//                dir       in  1        1 = left (SHIFT_LEFT_EN builds only)
//                work_next out WIDTH    shifted value
//  Config      : SHIFT_LEFT_EN - builds the left-shift path
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   work,
    input  logic [SHAMT_W-1:0] s,
    input  logic               fill,
    input  logic               dir,
    output logic [WIDTH-1:0]   work_next
);

    logic [WIDTH-1:0] w_right;

    // Logical shift, then OR ones into the vacated top bits for sign fill.
    assign w_right = (work >> s) | (fill ? ~({WIDTH{1'b1}} >> s) : '0);

`ifdef SHIFT_LEFT_EN
    assign work_next = dir ? (work << s) : w_right;
`else
    logic w_unused_dir;
    assign w_unused_dir = dir;
    assign work_next    = w_right;
`endif

endmodule
`default_nettype wire

// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
//  Module      : shift_right_seq
//  Description : Multi-cycle logical/arithmetic right shifter with a
//                start/done handshake. Shifts STEP bits per clock; the
//                result is held from done until the next accepted start.
//  Ports       : clk      in   1        clock, rising edge
//                rst_n    in   1        asynchronous active-low reset
//                start    in   1        request, sampled only in IDLE
//                data_in  in   WIDTH    operand, captured on accept
//                shamt    in   SHAMT_W  shift amount, captured on accept
//                arith    in   1        1 = sign fill, 0 = zero fill
//                dir      in   1        1 = left (SHIFT_LEFT_EN builds only)
//                busy     out  1        high in SHIFT and DONE
//                done     out  1        one-cycle completion pulse
//                result   out  WIDTH    shifted value
//  Config      : SHIFT_LEFT_EN - enables logical left shift via dir=1
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_right_seq #(
    parameter int WIDTH   = mips_pkg::c_width,
    parameter int STEP    = 1,
    parameter int SHAMT_W = mips_pkg::c_shamt_w
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    input  logic               dir,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    import mips_pkg::*;

    localparam logic [SHAMT_W-1:0] c_step = SHAMT_W'(STEP);

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_work_step;
    logic [SHAMT_W-1:0] r_count;
    logic [SHAMT_W-1:0] w_s;
    shift_op_e          r_op;
    shift_op_e          w_op_in;
    logic               r_sign;
    logic               w_fill;
    logic               w_left;
    logic               w_accept;
    logic               w_last;

    // Operation decode at the accepting edge.
`ifdef SHIFT_LEFT_EN
    assign w_op_in = dir ? SH_SLL : (arith ? SH_SRA : SH_SRL);
`else
    logic w_unused_dir;
    assign w_unused_dir = dir;
    assign w_op_in      = arith ? SH_SRA : SH_SRL;
`endif

    // s = min(STEP, count); shamt < WIDTH so s never exceeds count.
    assign w_s      = (r_count < c_step) ? r_count : c_step;
    // This step consumes the whole remaining count.
    assign w_last   = (r_count == w_s);
    assign w_accept = (r_state == ST_IDLE) && start;

    // Fill uses the sign captured at accept, not the evolving work value.
    assign w_fill = (r_op == SH_SRA) && r_sign;
    assign w_left = (r_op == SH_SLL);

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .work      (r_work),
        .s         (w_s),
        .fill      (w_fill),
        .dir       (w_left),
        .work_next (w_work_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: work register, counter, captured operation and result.
    // result is loaded only on the edge that enters DONE so it is valid
    // together with the done pulse and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_op     <= SH_SRL;
            r_sign   <= 1'b0;
        end else if (w_accept) begin
            r_work  <= data_in;
            r_count <= shamt;
            r_sign  <= data_in[WIDTH-1];
            r_op    <= w_op_in;
            if (shamt == '0) begin
                r_result <= data_in;
            end
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_work_step;
            r_count <= r_count - w_s;
            if (w_last) begin
                r_result <= w_work_step;
            end
        end
    end

    assign busy   = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_right_seq
//  Description : Self-checking bench for shift_right_seq. Two instances:
//                STEP=1 (dut1) and STEP=4 (dut4) share operand inputs and
//                have independent start lines. Directed vector table plus
//                hand-written sequences for ignored starts and reset abort.
//  Config      : SHIFT_LEFT_EN - adds left-shift vectors
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_right_seq;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start4;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        dir;
    logic        busy1, done1;
    logic        busy4, done4;
    logic [31:0] result1, result4;

    int n_cmp = 0;
    int n_err = 0;

    shift_right_seq #(.WIDTH(32), .STEP(1), .SHAMT_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data_in),
        .shamt(shamt), .arith(arith), .dir(dir),
        .busy(busy1), .done(done1), .result(result1)
    );

    shift_right_seq #(.WIDTH(32), .STEP(4), .SHAMT_W(5)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .data_in(data_in),
        .shamt(shamt), .arith(arith), .dir(dir),
        .busy(busy4), .done(done4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          which;   // 1 -> dut1 (STEP=1), 4 -> dut4 (STEP=4)
        logic [31:0] data;
        logic [4:0]  sh;
        logic        ar;
        logic        dr;
        logic [31:0] exp;
        int          lat;     // edges from accepting edge to done, inclusive
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        logic d;
        @(negedge clk);
        data_in = v.data;
        shamt   = v.sh;
        arith   = v.ar;
        dir     = v.dr;
        if (v.which == 1) start1 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start4 = 1'b0;
        // scramble don't-care inputs after the accepting edge
        data_in = ~v.data;
        shamt   = ~v.sh;
        arith   = ~v.ar;
        n = 1;
        d = (v.which == 1) ? done1 : done4;
        while (!d && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            d = (v.which == 1) ? done1 : done4;
        end
        if (!d) begin
            n_cmp++;
            n_err++;
            $display("FAIL vec%0d timeout: no done after %0d edges, expected %0d", idx, n, v.lat);
            return;
        end
        check($sformatf("vec%0d latency", idx), 32'(n), 32'(v.lat));
        check($sformatf("vec%0d result", idx), (v.which == 1) ? result1 : result4, v.exp);
        @(posedge clk);
        #1;
        check($sformatf("vec%0d done/busy after", idx),
              (v.which == 1) ? {30'd0, busy1, done1} : {30'd0, busy4, done4}, 32'd0);
        check($sformatf("vec%0d result held", idx), (v.which == 1) ? result1 : result4, v.exp);
    endtask

    initial begin
        int   n;
        int   pulses;
        logic seen;

        rst_n   = 1'b0;
        start1  = 1'b0;
        start4  = 1'b0;
        data_in = '0;
        shamt   = '0;
        arith   = 1'b0;
        dir     = 1'b0;

        //                which data          sh  ar  dr  expected      lat
        vecs.push_back('{1, 32'h8000_00F0,  4, 0, 0, 32'h0800_000F,  5});
        vecs.push_back('{1, 32'h8000_00F0,  4, 1, 0, 32'hF800_000F,  5});
        vecs.push_back('{1, 32'h1234_5678,  0, 0, 0, 32'h1234_5678,  1});
        vecs.push_back('{1, 32'h8000_0000, 31, 1, 0, 32'hFFFF_FFFF, 32});
        vecs.push_back('{1, 32'hA5A5_A5A5,  8, 1, 0, 32'hFFA5_A5A5,  9});
        vecs.push_back('{1, 32'h7FFF_FFFF,  1, 1, 0, 32'h3FFF_FFFF,  2});
        vecs.push_back('{4, 32'h0000_0F80,  7, 0, 0, 32'h0000_001F,  3});
        vecs.push_back('{4, 32'h8000_0000, 31, 1, 0, 32'hFFFF_FFFF,  9});
        vecs.push_back('{4, 32'h1234_5678, 16, 0, 0, 32'h0000_1234,  5});
        vecs.push_back('{4, 32'h8765_4321,  0, 1, 0, 32'h8765_4321,  1});
        vecs.push_back('{4, 32'hF000_0000,  5, 1, 0, 32'hFF80_0000,  3});
        vecs.push_back('{4, 32'h8000_0000, 31, 0, 0, 32'h0000_0001,  9});
`ifdef SHIFT_LEFT_EN
        vecs.push_back('{4, 32'h0000_0001,  2, 0, 1, 32'h0000_0004,  2});
        vecs.push_back('{1, 32'h8000_000F,  4, 1, 1, 32'h0000_00F0,  5});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy/done", {28'd0, busy1, done1, busy4, done4}, 32'd0);
        check("reset result1", result1, 32'd0);
        check("reset result4", result4, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Start while busy is ignored; start in DONE cycle is ignored
        @(negedge clk);
        data_in = 32'h8000_00F0; shamt = 5'd4; arith = 1'b0; dir = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        pulses = 0;
        @(negedge clk);
        data_in = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("ign busy during shift", {31'd0, busy1}, 32'd1);
        n = 0;
        seen = done1;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = done1;
        end
        if (seen) pulses++;
        check("ign done reached", {31'd0, seen}, 32'd1);
        check("ign result", result1, 32'h0800_000F);
        // start asserted during the DONE cycle
        data_in = 32'h1111_1111; shamt = 5'd0; arith = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("done-cycle start ignored", {30'd0, busy1, done1}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (done1) pulses++;
            @(posedge clk);
            #1;
        end
        check("ign done pulse count", 32'(pulses), 32'd1);
        check("ign result held idle", result1, 32'h0800_000F);

        // Reset mid-SHIFT aborts immediately, no done afterwards
        @(negedge clk);
        data_in = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre-reset busy", {31'd0, busy1}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst busy/done", {30'd0, busy1, done1}, 32'd0);
        check("rst result1", result1, 32'd0);
        check("rst result4", result4, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done1 || busy1) pulses++;
        end
        check("no done after reset", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
